// File: rtl/ben_cpu_pkg.sv
// Shared ben_cpu definitions: opcodes, control-word bit positions and widths.
package ben_cpu_pkg;

   localparam int CTRL_W = 16;

   typedef logic [CTRL_W-1:0] ctrl_t;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_LDA = 4'h1,
      OP_ADD = 4'h2,
      OP_SUB = 4'h3,
      OP_STA = 4'h4,
      OP_LDI = 4'h5,
      OP_JMP = 4'h6,
      OP_JC  = 4'h7,
      OP_JZ  = 4'h8,
      OP_OUT = 4'hE,
      OP_HLT = 4'hF
   } opcode_e;

   localparam int CTRL_HLT = 15;
   localparam int CTRL_MI  = 14;
   localparam int CTRL_RI  = 13;
   localparam int CTRL_RO  = 12;
   localparam int CTRL_IO  = 11;
   localparam int CTRL_II  = 10;
   localparam int CTRL_AI  = 9;
   localparam int CTRL_AO  = 8;
   localparam int CTRL_EO  = 7;
   localparam int CTRL_SU  = 6;
   localparam int CTRL_BI  = 5;
   localparam int CTRL_OI  = 4;
   localparam int CTRL_CE  = 3;
   localparam int CTRL_CO  = 2;
   localparam int CTRL_J   = 1;
   localparam int CTRL_FI  = 0;

   // Word presented for the whole time the CPU sits halted.
   localparam ctrl_t CTRL_HALT_WORD = ctrl_t'(1) << CTRL_HLT;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: (opcode, micro-step, C, Z) -> control word.
module microcode_rom
   import ben_cpu_pkg::*;
(
   input  logic [3:0]        opcode_i,
   input  logic [2:0]        step_i,
   input  logic              flag_c_i,
   input  logic              flag_z_i,
   output logic [CTRL_W-1:0] ctrl_o
);

   // Fetch is common to every opcode; execute words start at T2.
   always_comb begin
      ctrl_o = '0;
      case (step_i)
         3'd0: begin
            ctrl_o[CTRL_MI] = 1'b1;
            ctrl_o[CTRL_CO] = 1'b1;
         end
         3'd1: begin
            ctrl_o[CTRL_RO] = 1'b1;
            ctrl_o[CTRL_II] = 1'b1;
            ctrl_o[CTRL_CE] = 1'b1;
         end
         3'd2: begin
            case (opcode_i)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  ctrl_o[CTRL_IO] = 1'b1;
                  ctrl_o[CTRL_MI] = 1'b1;
               end
               OP_LDI: begin
                  ctrl_o[CTRL_IO] = 1'b1;
                  ctrl_o[CTRL_AI] = 1'b1;
               end
               OP_JMP: begin
                  ctrl_o[CTRL_IO] = 1'b1;
                  ctrl_o[CTRL_J]  = 1'b1;
               end
               OP_JC: begin
                  ctrl_o[CTRL_IO] = flag_c_i;
                  ctrl_o[CTRL_J]  = flag_c_i;
               end
               OP_JZ: begin
                  ctrl_o[CTRL_IO] = flag_z_i;
                  ctrl_o[CTRL_J]  = flag_z_i;
               end
               OP_OUT: begin
                  ctrl_o[CTRL_AO] = 1'b1;
                  ctrl_o[CTRL_OI] = 1'b1;
               end
               OP_HLT: ctrl_o[CTRL_HLT] = 1'b1;
               default: ;
            endcase
         end
         3'd3: begin
            case (opcode_i)
               OP_LDA: begin
                  ctrl_o[CTRL_RO] = 1'b1;
                  ctrl_o[CTRL_AI] = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  ctrl_o[CTRL_RO] = 1'b1;
                  ctrl_o[CTRL_BI] = 1'b1;
               end
               OP_STA: begin
                  ctrl_o[CTRL_AO] = 1'b1;
                  ctrl_o[CTRL_RI] = 1'b1;
               end
               default: ;
            endcase
         end
         3'd4: begin
            if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
               ctrl_o[CTRL_EO] = 1'b1;
               ctrl_o[CTRL_AI] = 1'b1;
               ctrl_o[CTRL_FI] = 1'b1;
               ctrl_o[CTRL_SU] = (opcode_i == OP_SUB);
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// ben_cpu micro-step sequencer: step counter, halt latch and output gating.
//
// state            | meaning
// halted_q=0, T0   | fetch: PC onto bus, load MAR
// halted_q=0, T1   | fetch: RAM into IR, increment PC
// halted_q=0, T2+  | execute steps of the opcode in IR
// halted_q=1       | stopped; step frozen, only reset leaves
module control_sequencer
   import ben_cpu_pkg::*;
#(
   parameter int STEPS      = 5,
   parameter bit EARLY_WRAP = 1'b1
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_enable,
   input  logic [3:0]        i_opcode,
   input  logic              i_flag_c,
   input  logic              i_flag_z,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic [2:0]        o_step,
   output logic              o_halted
);

   localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

   logic [2:0]        step_q, step_d;
   logic              halted_q, halted_d;
   logic [CTRL_W-1:0] rom_word;
   logic [STEPS-1:2]  ahead_nz;
   logic              rest_zero;

   microcode_rom u_rom_cur (
      .opcode_i (i_opcode),
      .step_i   (step_q),
      .flag_c_i (i_flag_c),
      .flag_z_i (i_flag_z),
      .ctrl_o   (rom_word)
   );

   // Lookahead ROMs see both flags as set: flags only count in T2, so a
   // conditional jump must always reach T2 before its outcome is known.
   for (genvar k = 2; k < STEPS; k++) begin : g_ahead
      logic [CTRL_W-1:0] word;
      microcode_rom u_rom_ahead (
         .opcode_i (i_opcode),
         .step_i   (3'(k)),
         .flag_c_i (1'b1),
         .flag_z_i (1'b1),
         .ctrl_o   (word)
      );
      assign ahead_nz[k] = |word;
   end

   // Every step after the current one decodes to an all-zero word.
   always_comb begin
      rest_zero = 1'b1;
      for (int k = 2; k < STEPS; k++) begin
         if (3'(k) > step_q && ahead_nz[k]) rest_zero = 1'b0;
      end
   end

   // Output gating: halt word overrides everything, a stall blanks the word.
   always_comb begin
      o_ctrl = rom_word;
      if (halted_q)       o_ctrl = CTRL_HALT_WORD;
      else if (!i_enable) o_ctrl = '0;
   end

   // Next step / halt decision; the halting edge also freezes the step.
   always_comb begin
      step_d   = step_q;
      halted_d = halted_q;
      if (!halted_q && i_enable) begin
         if (o_ctrl[CTRL_HLT]) begin
            halted_d = 1'b1;
         end else if (step_q == LAST_STEP ||
                      (EARLY_WRAP && step_q != 3'd0 && rest_zero)) begin
            step_d = 3'd0;
         end else begin
            step_d = step_q + 3'd1;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         step_q   <= 3'd0;
         halted_q <= 1'b0;
      end else begin
         step_q   <= step_d;
         halted_q <= halted_d;
      end
   end

   assign o_step   = step_q;
   assign o_halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: two sequencers (early wrap on/off) driven by the same
// stimulus, compared each cycle against an instruction-level reference.
module tb_control_sequencer;

   localparam int STEPS = 5;

   logic        clk = 1'b0;
   logic        rst, en, fc, fz;
   logic [3:0]  op;
   logic [15:0] ctrl_w, ctrl_n;
   logic [2:0]  step_w, step_n;
   logic        halt_w, halt_n;

   always #5 clk = ~clk;

   control_sequencer #(.STEPS(STEPS), .EARLY_WRAP(1'b1)) dut_w (
      .i_clk(clk), .i_rst(rst), .i_enable(en), .i_opcode(op),
      .i_flag_c(fc), .i_flag_z(fz),
      .o_ctrl(ctrl_w), .o_step(step_w), .o_halted(halt_w)
   );

   control_sequencer #(.STEPS(STEPS), .EARLY_WRAP(1'b0)) dut_n (
      .i_clk(clk), .i_rst(rst), .i_enable(en), .i_opcode(op),
      .i_flag_c(fc), .i_flag_z(fz),
      .o_ctrl(ctrl_n), .o_step(step_n), .o_halted(halt_n)
   );

   typedef struct {
      logic [15:0] ctrl_w;
      logic [2:0]  step_w;
      logic        halt_w;
      logic [15:0] ctrl_n;
      logic [2:0]  step_n;
      logic        halt_n;
   } exp_t;

   exp_t sb[$];
   int total = 0;
   int bad   = 0;

   // Last micro-step of each opcode that can carry a non-zero word.
   int last_pos [16] = '{1, 3, 4, 4, 3, 2, 2, 2, 2, 1, 1, 1, 1, 1, 2, 2};

   // Instruction table: T0/T1 fetch, then per-opcode execute words.
   function automatic logic [15:0] ref_word(input logic [3:0] o, input int t,
                                            input logic c, input logic z);
      logic [15:0] w;
      w = 16'h0000;
      if (t == 0) return 16'h4004;
      if (t == 1) return 16'h1408;
      case (o)
         4'h1: if (t == 2) w = 16'h4800; else if (t == 3) w = 16'h1200;
         4'h2: if (t == 2) w = 16'h4800; else if (t == 3) w = 16'h1020;
               else if (t == 4) w = 16'h0281;
         4'h3: if (t == 2) w = 16'h4800; else if (t == 3) w = 16'h1020;
               else if (t == 4) w = 16'h02C1;
         4'h4: if (t == 2) w = 16'h4800; else if (t == 3) w = 16'h2100;
         4'h5: if (t == 2) w = 16'h0A00;
         4'h6: if (t == 2) w = 16'h0802;
         4'h7: if (t == 2 && c) w = 16'h0802;
         4'h8: if (t == 2 && z) w = 16'h0802;
         4'hE: if (t == 2) w = 16'h0110;
         4'hF: if (t == 2) w = 16'h8000;
         default: ;
      endcase
      return w;
   endfunction

   int  pos_w = 0, pos_n = 0;
   bit  hl_w = 0,  hl_n = 0;

   function automatic logic [15:0] expect_word(input int pos, input bit hl);
      if (hl)  return 16'h8000;
      if (!en) return 16'h0000;
      return ref_word(op, pos, fc, fz);
   endfunction

   task automatic advance(input bit wrap, input logic [15:0] w,
                          inout int pos, inout bit hl);
      if (rst) begin
         pos = 0;
         hl  = 0;
      end else if (!hl && en) begin
         if (w[15]) hl = 1;
         else if (pos == STEPS - 1 || (wrap && pos >= 1 && pos >= last_pos[op])) pos = 0;
         else pos = pos + 1;
      end
   endtask

   // Drive one cycle, push the expected outputs, then let the edge happen.
   task automatic cycle(input logic r, input logic e, input logic [3:0] o,
                        input logic c, input logic z);
      exp_t x;
      rst = r; en = e; op = o; fc = c; fz = z;
      x.ctrl_w = expect_word(pos_w, hl_w);
      x.step_w = 3'(pos_w);
      x.halt_w = hl_w;
      x.ctrl_n = expect_word(pos_n, hl_n);
      x.step_n = 3'(pos_n);
      x.halt_n = hl_n;
      sb.push_back(x);
      advance(1'b1, x.ctrl_w, pos_w, hl_w);
      advance(1'b0, x.ctrl_n, pos_n, hl_n);
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
      end
   endtask

   // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("ctrl_wrap",  ctrl_w,       x.ctrl_w);
            chk("step_wrap",  16'(step_w),  16'(x.step_w));
            chk("halt_wrap",  16'(halt_w),  16'(x.halt_w));
            chk("ctrl_full",  ctrl_n,       x.ctrl_n);
            chk("step_full",  16'(step_n),  16'(x.step_n));
            chk("halt_full",  16'(halt_n),  16'(x.halt_n));
         end
      end
   end

   initial begin
      logic [3:0] rop;
      int guard;
      rst = 1'b1; en = 1'b1; op = 4'h0; fc = 1'b0; fz = 1'b0;
      @(posedge clk);
      #2;
      // ADD then LDI back to back
      for (int i = 0; i < 5; i++) cycle(0, 1, 4'h2, 0, 0);
      for (int i = 0; i < 5; i++) cycle(0, 1, 4'h5, 0, 0);
      // JC taken / not taken, JZ with z wiggling before T2
      cycle(1, 1, 4'h7, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 4'h7, 1, 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 4'h7, 0, 0);
      cycle(0, 1, 4'h8, 0, 1);
      cycle(0, 1, 4'h8, 0, 0);
      cycle(0, 1, 4'h8, 0, 1);
      // ADD stalled at T3, then reset mid-instruction
      cycle(1, 1, 4'h2, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 4'h2, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 4'h2, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 4'h2, 0, 0);
      cycle(1, 1, 4'h2, 0, 0);
      cycle(0, 1, 4'h2, 0, 0);
      // HLT, then opcode noise while halted, then reset
      cycle(1, 1, 4'hF, 0, 0);
      for (int i = 0; i < 24; i++) cycle(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 0, 0);
      cycle(1, 1, 4'h0, 0, 0);
      cycle(0, 1, 4'h0, 0, 0);
      // Random traffic
      rop = 4'h0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 39) == 0) rop = 4'hF;
            else rop = 4'($urandom_range(0, 14));
         end
         cycle(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 5) != 0), rop,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      guard = 0;
      while (sb.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      if (sb.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain pending=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
